// File: rtl/pipe_stage_buf_pkg.sv
// -----------------------------------------------------------------------------
// pipe_stage_buf_pkg
//   Shared pipeline definitions.
//   - Stage-boundary payload structs (IF/ID, ID/EX, EX/MEM, MEM/WB).
//   - Default buffer depth and ready mode for every stage boundary.
//   - Per-boundary payload widths, used as DATA_W when instantiating
//     pipe_stage_buf.
//   - Pointer-width helper shared by the buffer and its pointer sub-module.
// -----------------------------------------------------------------------------
package pipe_stage_buf_pkg;

  // Default configuration applied on every stage boundary.
  parameter int PIPE_BUF_DEPTH  = 2;
  parameter int PIPE_PASS_READY = 1;

  // Largest supported buffer depth.
  localparam int PIPE_BUF_MAX_DEPTH = 8;

  // Stage payloads. The buffer never looks inside them: it carries them as
  // opaque bit vectors. The "enable" bit mirrors out_valid of the buffer that
  // carries the struct.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        enable;
  } IFID_Pipe_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [3:0]  alu_op;
    logic        enable;
  } IDEX_Pipe_t;

  typedef struct packed {
    logic [31:0] alu_res;
    logic [31:0] rs2_val;
    logic [4:0]  rd;
    logic        mem_rd;
    logic        mem_wr;
    logic        reg_wr;
    logic        enable;
  } EXMEM_Pipe_t;

  typedef struct packed {
    logic [31:0] wb_data;
    logic [4:0]  rd;
    logic        reg_wr;
    logic        enable;
  } MEMWB_Pipe_t;

  // Payload widths per boundary.
  localparam int IFID_W  = $bits(IFID_Pipe_t);
  localparam int IDEX_W  = $bits(IDEX_Pipe_t);
  localparam int EXMEM_W = $bits(EXMEM_Pipe_t);
  localparam int MEMWB_W = $bits(MEMWB_Pipe_t);

  // Width of a pointer that addresses DEPTH entries. A single-entry buffer
  // still gets a 1-bit pointer so that no zero-width vectors appear.
  function automatic int pipe_buf_ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/pipe_buf_ptr.sv
// -----------------------------------------------------------------------------
// pipe_buf_ptr
//   Circular index into a DEPTH-entry store. Wraps DEPTH-1 -> 0 explicitly, so
//   non-power-of-2 depths work.
//   Ports:
//     clk       rising-edge clock
//     clr       synchronous clear to 0 (highest priority)
//     load      synchronous load of load_val (beats inc)
//     load_val  value to load
//     inc       advance by one with wrap
//     ptr       current pointer value
// -----------------------------------------------------------------------------
module pipe_buf_ptr
  import pipe_stage_buf_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PTR_W = pipe_buf_ptr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load,
  input  logic [PTR_W-1:0] load_val,
  input  logic             inc,
  output logic [PTR_W-1:0] ptr
);

  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create ordering-dependent races.
  always_ff @(posedge clk) begin
    if (clr) begin
      ptr <= '0;
    end else if (load) begin
      ptr <= load_val;
    end else if (inc) begin
      ptr <= (ptr == LAST) ? '0 : ptr + PTR_W'(1);
    end
  end

endmodule

// File: rtl/pipe_stage_buf.sv
// -----------------------------------------------------------------------------
// pipe_stage_buf
//   Elastic register between two pipeline stages. Holds up to DEPTH opaque
//   payloads with a valid/ready handshake on both sides and a synchronous
//   flush for branch squash. The output is always read from registered
//   storage, so latency is at least one cycle and there is no in->out path.
//   Ports:
//     clk        rising-edge clock
//     rst        synchronous active-high reset; discards everything
//     in_valid   producer offers in_data
//     in_ready   buffer accepts this cycle
//     in_data    payload from the upstream stage
//     out_valid  head entry valid
//     out_ready  consumer takes the head; low to stall
//     out_data   head entry payload
//     flush      squash all held entries; a same-cycle push is dropped
//     count      occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module pipe_stage_buf
  import pipe_stage_buf_pkg::*;
#(
  parameter  int DATA_W     = 64,
  parameter  int DEPTH      = PIPE_BUF_DEPTH,
  parameter  int PASS_READY = PIPE_PASS_READY,
  localparam int CNT_W      = $clog2(DEPTH + 1),
  localparam int PTR_W      = pipe_buf_ptr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  output logic [CNT_W-1:0]  count
);

  if (DEPTH < 1 || DEPTH > PIPE_BUF_MAX_DEPTH || DATA_W < 1) begin : g_param_check
    $error("pipe_stage_buf: DEPTH must be in 1..8 and DATA_W must be >= 1");
  end

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              not_full;
  logic              push;
  logic              pop;

  assign not_full  = (count < CNT_W'(DEPTH));
  assign out_valid = (count != '0);
  assign out_data  = mem[rd_ptr];

  // With PASS_READY a full buffer still accepts when the head leaves in the
  // same cycle; otherwise in_ready depends on registered occupancy only,
  // which breaks the ready chain between stages.
  if (PASS_READY != 0) begin : g_pass_ready
    assign in_ready = not_full || out_ready;
  end else begin : g_reg_ready
    assign in_ready = not_full;
  end

  // The flushed producer still sees its beat accepted; the beat is simply
  // not stored.
  assign push = in_valid && in_ready && !flush;
  assign pop  = out_valid && out_ready && !flush;

  // Write pointer only ever advances or resets. On flush the read pointer
  // jumps to the write pointer, emptying the ring without touching storage.
  pipe_buf_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
    .clk      (clk),
    .clr      (rst),
    .load     (1'b0),
    .load_val ('0),
    .inc      (push),
    .ptr      (wr_ptr)
  );

  pipe_buf_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
    .clk      (clk),
    .clr      (rst),
    .load     (flush),
    .load_val (wr_ptr),
    .inc      (pop),
    .ptr      (rd_ptr)
  );

  // NOTE: storage is cleared on reset on purpose so out_data reads 0 after
  // reset; a plain pipeline store would normally be left unreset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      count <= '0;
    end else begin
      unique case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Occupancy can never leave 0..DEPTH and the head is never taken from an
  // empty buffer.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (count <= CNT_W'(DEPTH))
        else $error("pipe_stage_buf: count exceeds DEPTH");
      assert (!(pop && count == '0))
        else $error("pipe_stage_buf: pop while empty");
    end
  end

endmodule

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
- Parametrised elastic register between two pipeline stages, generalising the fixed IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Payload is an opaque packed vector, normally one stage struct (e.g. IDEX_Pipe_t) cast to bits.
- Adds a valid/ready handshake, configurable depth (plain register, skid buffer or small FIFO), a registered-ready mode and a synchronous flush for branch squash.
- One instance sits on each stage boundary.

Parameters:
- DATA_W, 64, payload width in bits; instantiate with the $bits of the stage struct.
- DEPTH, 2, number of entries, 1..8; non-power-of-2 allowed.
- PASS_READY, 1:
  - 1: in_ready may depend combinationally on out_ready.
  - 0: in_ready is a function of registered state only.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  producer offers in_data.
- in_ready  output  1  buffer accepts this cycle.
- in_data  input  DATA_W  payload from the upstream stage.
- out_valid  output  1  head entry valid; equivalent to the struct "enable" bit.
- out_ready  input  1  consumer takes the head; driven low to stall.
- out_data  output  DATA_W  head entry payload.
- flush  input  1  squash all held entries (mispredict/redirect).
- count  output  $clog2(DEPTH+1)  occupancy.

Behaviour:
- Handshake and pointers:
  - push = in_valid && in_ready && !flush.
  - pop = out_valid && out_ready && !flush.
  - Circular storage: wr_ptr and rd_ptr each wrap DEPTH-1 -> 0 explicitly; modulo 2^n is not used.
- Outputs:
  - out_valid = (count != 0).
  - out_data = mem[rd_ptr], read combinationally from registered storage. No combinational path from in_data to out_data.
- Latency: an entry pushed in cycle N is visible at the outputs in cycle N+1 when empty. Minimum latency is 1; there is no bypass.
- in_ready:
  - PASS_READY=1: in_ready = (count < DEPTH) || out_ready. When full, a simultaneous pop and push is allowed and count is unchanged.
  - PASS_READY=0: in_ready = (count < DEPTH). With DEPTH>=2 this still sustains 1 transfer/cycle. PASS_READY=0 with DEPTH=1 gives at most 1 transfer per 2 cycles; this is legal and documented.
- count update:
  - push only: +1.
  - pop only: -1.
  - both: unchanged.
  - neither: unchanged.
- flush:
  - count <= 0, rd_ptr <= wr_ptr (pointers aligned), out_valid low next cycle.
  - A push offered in the same cycle is dropped.
  - in_ready keeps its normal value during flush; the producer sees its beat accepted and discarded, because it is wrong-path.
  - flush has priority over push and pop.
- rst:
  - count=0, wr_ptr=rd_ptr=0, all mem entries 0.
  - Outputs after reset: out_valid=0, out_data=0, count=0. in_ready: 1 in either mode.
  - rst mid-operation discards all entries the same way as flush. rst has priority over flush.
- Data stability: while out_valid && !out_ready, out_data and out_valid hold unchanged, except when flush or rst is asserted.
- Overflow/underflow: not possible by construction. Assertions required:
  - count never exceeds DEPTH.
  - no pop when count == 0.
  - in_valid held while !in_ready is not mandated of the producer.
- Elaboration: DEPTH must be in 1..8 and DATA_W >= 1; generate an elaboration error otherwise.

Decomposition:
- pipeline_pkg additions:
  - parameter PIPE_BUF_DEPTH = 2.
  - parameter PIPE_PASS_READY = 1.
  - per-boundary widths: localparam IFID_W = $bits(IFID_Pipe_t), and likewise IDEX_W, EXMEM_W, MEMWB_W.
- Stage structs stay in the package; this module stays payload-agnostic.
- One sub-module: pipe_buf_ptr, a wrap-at-DEPTH pointer with inc and clr (used twice: wr_ptr, rd_ptr).

Test Plan:
- Reset then idle (DEPTH=2, DATA_W=64): rst high 2 cycles, then low -> out_valid=0, count=0, in_ready=1, out_data=0.
- Streaming: in_valid=1 with values 0x10..0x17 on consecutive cycles, out_ready=1 -> outputs 0x10..0x17 each one cycle later, count stays 1, no bubbles. Run for PASS_READY 0 and 1.
- Stall/fill (DEPTH=2, PASS_READY=0): push 0xA, 0xB with out_ready=0 -> count=2, in_ready=0, out_data=0xA held. Then out_ready=1 -> 0xA, 0xB emitted in order, in_ready=1 after the first pop.
- Full with simultaneous push/pop (DEPTH=1, PASS_READY=1): hold 0x5, then assert out_ready=1 and in_valid=1 with 0x6 -> next cycle out_data=0x6, count=1.
- Flush priority: count=2 holding 0x1, 0x2; assert flush with in_valid=1 (0x3) and out_ready=1 -> next cycle count=0, out_valid=0, 0x3 never appears. Next push of 0x4 appears alone.
- Wrap (DEPTH=3): 7 pushes interleaved with pops in pattern push,push,pop,push,pop,pop,... -> output order equals input order across pointer wrap, count matches the reference model each cycle.
